// File: rtl/trap_request_arbiter.sv
// Trap request arbiter: picks one trap per event from ID/EX/MEM exceptions and the
// external interrupt, issues the request pulse and flushes until the redirect returns.
module trap_request_arbiter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] INTR_CAUSE  = 32'h8000_000B
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        intr_async,
  input  logic        mstatus_mie,
  input  logic        mie_meie,
  input  logic        id_exc_v,
  input  logic [31:0] id_exc_cause,
  input  logic [31:0] id_pc,
  input  logic        ex_exc_v,
  input  logic [31:0] ex_exc_cause,
  input  logic [31:0] ex_pc,
  input  logic        mem_exc_v,
  input  logic [31:0] mem_exc_cause,
  input  logic [31:0] mem_pc,
  input  logic [31:0] intr_pc,
  input  logic        mret_commit,
  input  logic        take_trap,
  output logic        intr_synced,
  output logic        take_trap_raw,
  output logic        trap_set,
  output logic [31:0] trap_cause,
  output logic [31:0] trap_pc,
  output logic        cu_intr_ack,
  output logic        flush_pipe,
  output logic        in_handler,
  output logic        redir_err
);

  // state      | meaning
  // IDLE       | no trap in flight; arbitrate requests
  // ISSUE      | request pulse out; redirect may return this cycle
  // WAIT_REDIR | one-cycle grace for a late redirect, else flag redir_err
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ISSUE      = 2'd1,
    ST_WAIT_REDIR = 2'd2
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_is_intr;
  logic                   r_take_trap_raw;
  logic                   r_trap_set;
  logic [31:0]            r_trap_cause;
  logic [31:0]            r_trap_pc;
  logic                   r_cu_intr_ack;
  logic                   r_flush_pipe;
  logic                   r_in_handler;
  logic                   r_redir_err;

  logic                   w_intr_elig;
  logic                   w_req_any;
  logic [31:0]            w_sel_cause;
  logic [31:0]            w_sel_pc;
  logic                   w_sel_intr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], intr_async};
    end
  end

  assign intr_synced = r_sync[SYNC_STAGES-1];
  assign w_intr_elig = intr_synced & mstatus_mie & mie_meie & ~r_in_handler;
  assign w_req_any   = mem_exc_v | ex_exc_v | id_exc_v | w_intr_elig;

  // Oldest faulting stage wins; the interrupt only when no exception is pending.
  always_comb begin
    w_sel_cause = INTR_CAUSE;
    w_sel_pc    = intr_pc;
    w_sel_intr  = 1'b1;
    if (mem_exc_v) begin
      w_sel_cause = mem_exc_cause;
      w_sel_pc    = mem_pc;
      w_sel_intr  = 1'b0;
    end else if (ex_exc_v) begin
      w_sel_cause = ex_exc_cause;
      w_sel_pc    = ex_pc;
      w_sel_intr  = 1'b0;
    end else if (id_exc_v) begin
      w_sel_cause = id_exc_cause;
      w_sel_pc    = id_pc;
      w_sel_intr  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state         <= ST_IDLE;
      r_is_intr       <= 1'b0;
      r_take_trap_raw <= 1'b0;
      r_trap_set      <= 1'b0;
      r_trap_cause    <= '0;
      r_trap_pc       <= '0;
      r_cu_intr_ack   <= 1'b0;
      r_flush_pipe    <= 1'b0;
      r_in_handler    <= 1'b0;
      r_redir_err     <= 1'b0;
    end else begin
      r_take_trap_raw <= 1'b0;
      r_trap_set      <= 1'b0;
      r_cu_intr_ack   <= 1'b0;
      // A redirect below overrides this clear in the same cycle.
      if (mret_commit) begin
        r_in_handler <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          r_flush_pipe <= 1'b0;
          if (w_req_any) begin
            r_state         <= ST_ISSUE;
            r_trap_cause    <= w_sel_cause;
            r_trap_pc       <= w_sel_pc;
            r_is_intr       <= w_sel_intr;
            r_take_trap_raw <= 1'b1;
            r_trap_set      <= 1'b1;
            r_flush_pipe    <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (take_trap) begin
            r_state       <= ST_IDLE;
            r_flush_pipe  <= 1'b0;
            r_in_handler  <= 1'b1;
            r_cu_intr_ack <= r_is_intr;
          end else begin
            r_state      <= ST_WAIT_REDIR;
            r_flush_pipe <= 1'b1;
          end
        end
        ST_WAIT_REDIR: begin
          r_state      <= ST_IDLE;
          r_flush_pipe <= 1'b0;
          if (take_trap) begin
            r_in_handler  <= 1'b1;
            r_cu_intr_ack <= r_is_intr;
          end else begin
            r_redir_err <= 1'b1;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_flush_pipe <= 1'b0;
        end
      endcase
    end
  end

  assign take_trap_raw = r_take_trap_raw;
  assign trap_set      = r_trap_set;
  assign trap_cause    = r_trap_cause;
  assign trap_pc       = r_trap_pc;
  assign cu_intr_ack   = r_cu_intr_ack;
  assign flush_pipe    = r_flush_pipe;
  assign in_handler    = r_in_handler;
  assign redir_err     = r_redir_err;

endmodule

// File: tb/tb_trap_request_arbiter.sv
// Bench for trap_request_arbiter: expected traps queued at stimulus time and
// compared when take_trap_raw appears; timing of flush/ack/in_handler checked inline.
module tb_trap_request_arbiter;

  localparam logic [31:0] INTR_CAUSE = 32'h8000_000B;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        intr_async = 1'b0;
  logic        mstatus_mie = 1'b0;
  logic        mie_meie = 1'b0;
  logic        id_exc_v = 1'b0;
  logic [31:0] id_exc_cause = '0;
  logic [31:0] id_pc = '0;
  logic        ex_exc_v = 1'b0;
  logic [31:0] ex_exc_cause = '0;
  logic [31:0] ex_pc = '0;
  logic        mem_exc_v = 1'b0;
  logic [31:0] mem_exc_cause = '0;
  logic [31:0] mem_pc = '0;
  logic [31:0] intr_pc = '0;
  logic        mret_commit = 1'b0;
  logic        take_trap = 1'b0;
  logic        intr_synced;
  logic        take_trap_raw;
  logic        trap_set;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic        cu_intr_ack;
  logic        flush_pipe;
  logic        in_handler;
  logic        redir_err;

  trap_request_arbiter #(.SYNC_STAGES(2), .INTR_CAUSE(INTR_CAUSE)) dut (
    .clk(clk), .rstn(rstn), .intr_async(intr_async),
    .mstatus_mie(mstatus_mie), .mie_meie(mie_meie),
    .id_exc_v(id_exc_v), .id_exc_cause(id_exc_cause), .id_pc(id_pc),
    .ex_exc_v(ex_exc_v), .ex_exc_cause(ex_exc_cause), .ex_pc(ex_pc),
    .mem_exc_v(mem_exc_v), .mem_exc_cause(mem_exc_cause), .mem_pc(mem_pc),
    .intr_pc(intr_pc), .mret_commit(mret_commit), .take_trap(take_trap),
    .intr_synced(intr_synced), .take_trap_raw(take_trap_raw), .trap_set(trap_set),
    .trap_cause(trap_cause), .trap_pc(trap_pc), .cu_intr_ack(cu_intr_ack),
    .flush_pipe(flush_pipe), .in_handler(in_handler), .redir_err(redir_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] cause;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_pulses = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] cause, input logic [31:0] pc);
    exp_t e;
    e.cause = cause;
    e.pc    = pc;
    sb.push_back(e);
  endtask

  // Scoreboard side: every request pulse must match the oldest queued trap.
  always @(negedge clk) begin
    if (rstn && take_trap_raw) begin
      n_pulses++;
      if (sb.size() == 0) begin
        chk("unexpected_trap", take_trap_raw, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_cause", trap_cause, e.cause);
        chk("sb_pc", trap_pc, e.pc);
        chk("sb_trap_set", trap_set, 1'b1);
      end
    end
  end

  initial begin
    int p0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_raw", take_trap_raw, 0);
    chk("rst_set", trap_set, 0);
    chk("rst_cause", trap_cause, 0);
    chk("rst_pc", trap_pc, 0);
    chk("rst_flush", flush_pipe, 0);
    chk("rst_inh", in_handler, 0);
    chk("rst_ack", cu_intr_ack, 0);
    chk("rst_err", redir_err, 0);
    chk("rst_sync", intr_synced, 0);
    rstn = 1'b1;
    tick();

    // EX exception, redirect in ISSUE
    ex_exc_v = 1'b1; ex_exc_cause = 32'd2; ex_pc = 32'h100;
    push_exp(32'd2, 32'h100);
    tick();
    ex_exc_v = 1'b0; take_trap = 1'b1;
    @(negedge clk);
    chk("ex_raw", take_trap_raw, 1);
    chk("ex_flush", flush_pipe, 1);
    chk("ex_inh_pre", in_handler, 0);
    tick();
    take_trap = 1'b0;
    @(negedge clk);
    chk("ex_raw_off", take_trap_raw, 0);
    chk("ex_set_off", trap_set, 0);
    chk("ex_flush_off", flush_pipe, 0);
    chk("ex_inh", in_handler, 1);
    chk("ex_ack", cu_intr_ack, 0);
    chk("ex_cause_hold", trap_cause, 32'd2);

    // all three stages at once; MRET coincides with the redirect
    p0 = n_pulses;
    tick();
    mem_exc_v = 1'b1; mem_exc_cause = 32'd5; mem_pc = 32'h200;
    ex_exc_v  = 1'b1; ex_exc_cause  = 32'd2; ex_pc  = 32'h204;
    id_exc_v  = 1'b1; id_exc_cause  = 32'd3; id_pc  = 32'h208;
    push_exp(32'd5, 32'h200);
    tick();
    mem_exc_v = 1'b0; ex_exc_v = 1'b0; id_exc_v = 1'b0;
    take_trap = 1'b1; mret_commit = 1'b1;
    @(negedge clk);
    chk("pri_cause", trap_cause, 32'd5);
    chk("pri_pc", trap_pc, 32'h200);
    tick();
    take_trap = 1'b0; mret_commit = 1'b0;
    @(negedge clk);
    chk("pri_set_wins", in_handler, 1);
    tick();
    @(negedge clk);
    chk("pri_one_pulse", n_pulses, p0 + 1);
    mret_commit = 1'b1;
    tick();
    mret_commit = 1'b0;
    @(negedge clk);
    chk("mret_clear", in_handler, 0);

    // external interrupt, late redirect
    mstatus_mie = 1'b1; mie_meie = 1'b1; intr_pc = 32'h340;
    tick();
    intr_async = 1'b1;
    push_exp(INTR_CAUSE, 32'h340);
    @(negedge clk);
    chk("sync_c0", intr_synced, 0);
    tick();
    @(negedge clk);
    chk("sync_c1", intr_synced, 0);
    tick();
    @(negedge clk);
    chk("sync_c2", intr_synced, 1);
    chk("intr_raw_early", take_trap_raw, 0);
    tick();
    @(negedge clk);
    chk("intr_raw", take_trap_raw, 1);
    chk("intr_flush_issue", flush_pipe, 1);
    tick();
    take_trap = 1'b1;
    @(negedge clk);
    chk("intr_raw_wait", take_trap_raw, 0);
    chk("intr_flush_wait", flush_pipe, 1);
    chk("intr_ack_early", cu_intr_ack, 0);
    tick();
    take_trap = 1'b0;
    @(negedge clk);
    chk("intr_ack", cu_intr_ack, 1);
    chk("intr_inh", in_handler, 1);
    chk("intr_flush_off", flush_pipe, 0);
    chk("intr_err", redir_err, 0);
    tick();
    @(negedge clk);
    chk("intr_ack_once", cu_intr_ack, 0);

    // interrupt held while in handler: no retrigger until MRET
    p0 = n_pulses;
    repeat (5) tick();
    @(negedge clk);
    chk("held_no_trap", n_pulses, p0);
    mret_commit = 1'b1;
    push_exp(INTR_CAUSE, 32'h340);
    tick();
    mret_commit = 1'b0;
    @(negedge clk);
    chk("held_inh_clr", in_handler, 0);
    chk("held_raw_early", take_trap_raw, 0);
    tick();
    take_trap = 1'b1;
    @(negedge clk);
    chk("held_raw", take_trap_raw, 1);
    tick();
    take_trap = 1'b0; intr_async = 1'b0;
    @(negedge clk);
    chk("held_ack", cu_intr_ack, 1);
    repeat (4) tick();

    // redirect never returned
    id_exc_v = 1'b1; id_exc_cause = 32'd3; id_pc = 32'h300;
    push_exp(32'd3, 32'h300);
    tick();
    id_exc_v = 1'b0;
    @(negedge clk);
    chk("noredir_raw", take_trap_raw, 1);
    tick();
    @(negedge clk);
    chk("noredir_flush", flush_pipe, 1);
    chk("noredir_err_early", redir_err, 0);
    tick();
    @(negedge clk);
    chk("noredir_err", redir_err, 1);
    chk("noredir_idle", flush_pipe, 0);
    repeat (3) tick();
    @(negedge clk);
    chk("noredir_sticky", redir_err, 1);

    // reset asserted during ISSUE
    mem_exc_v = 1'b1; mem_exc_cause = 32'd7; mem_pc = 32'h400;
    push_exp(32'd7, 32'h400);
    tick();
    mem_exc_v = 1'b0;
    @(negedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("mid_rst_raw", take_trap_raw, 0);
    chk("mid_rst_flush", flush_pipe, 0);
    chk("mid_rst_err", redir_err, 0);
    chk("mid_rst_cause", trap_cause, 0);
    chk("mid_rst_inh", in_handler, 0);
    @(negedge clk);
    rstn = 1'b1;
    p0 = n_pulses;
    repeat (4) begin
      tick();
      @(negedge clk);
      chk("post_rst_ack", cu_intr_ack, 0);
    end
    chk("post_rst_no_trap", n_pulses, p0);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/trap_request_arbiter.md
Name: trap_request_arbiter

Overview:
- Initiator side of the core's trap/redirect interface: it generates the trap request that the CSR pipeline adapter consumes.
- Collects exception requests from the ID, EX and MEM stages and the external interrupt line, then picks one trap per event.
- Drives the request pulse and the trap bookkeeping (cause, PC, trap_set), and flushes the pipe until the adapter's gated redirect (take_trap) returns.
- Issues cu_intr_ack for interrupt traps and tracks in-handler state until MRET commits.

Parameters:
- SYNC_STAGES, 2, flop depth of the intr_async synchronizer (minimum 2).
- INTR_CAUSE, 32'h8000_000B, mcause value for a machine external interrupt.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- intr_async  in  1  raw external interrupt, level, asynchronous to clk
- mstatus_mie  in  1  mstatus[3] from the CSR unit
- mie_meie  in  1  mie[11] from the CSR unit
- id_exc_v / ex_exc_v / mem_exc_v  in  1 each  stage exception valid
- id_exc_cause / ex_exc_cause / mem_exc_cause  in  32 each  exception cause
- id_pc / ex_pc / mem_pc  in  32 each  PC of the faulting instruction
- intr_pc  in  32  PC of the oldest uncommitted instruction (interrupt mepc)
- mret_commit  in  1  MRET committing in WB
- take_trap  in  1  gated redirect from the adapter (same cycle as the request, or one cycle later)
- intr_synced  out  1  synchronized interrupt level
- take_trap_raw  out  1  one-cycle trap request
- trap_set  out  1  one-cycle CSR bookkeeping strobe, coincident with take_trap_raw
- trap_cause  out  32  registered cause
- trap_pc  out  32  registered mepc value
- cu_intr_ack  out  1  one-cycle acknowledge for an interrupt trap
- flush_pipe  out  1  kill/stall the front end while a trap is in flight
- in_handler  out  1  set on redirect, cleared by MRET
- redir_err  out  1  sticky: redirect not seen within 1 cycle of the request

Behaviour:
- Reset (asynchronous): state IDLE; all outputs 0; synchronizer flops 0; trap_cause and trap_pc 0.
- Synchronizer: intr_synced = last flop of the SYNC_STAGES chain. A rising edge on intr_async is visible SYNC_STAGES cycles later.
- Interrupt eligibility: intr_elig = intr_synced & mstatus_mie & mie_meie & ~in_handler.
- Priority (evaluated only in IDLE), highest first:
  - mem_exc_v
  - ex_exc_v
  - id_exc_v
  - intr_elig, using cause INTR_CAUSE and PC intr_pc.
- FSM states: IDLE, ISSUE, WAIT_REDIR.
- IDLE:
  - If any request is present at cycle N, latch the winner's cause/PC into trap_cause/trap_pc and record is_intr; go to ISSUE.
  - take_trap_raw = trap_set = 1 in cycle N+1.
- ISSUE (exactly one cycle):
  - take_trap_raw = 1, trap_set = 1, flush_pipe = 1.
  - If take_trap = 1: redirect done, go to IDLE.
  - Else: go to WAIT_REDIR.
- WAIT_REDIR (exactly one cycle):
  - take_trap_raw = 0, flush_pipe = 1.
  - If take_trap = 1: redirect done.
  - Else: set redir_err (sticky until reset).
  - Go to IDLE in either case.
- On redirect done:
  - in_handler <= 1.
  - cu_intr_ack pulses 1 in the following cycle if is_intr, otherwise stays 0.
- flush_pipe = 1 in ISSUE and WAIT_REDIR, 0 in IDLE.
- Stage requests arriving while not in IDLE are ignored; the flush kills them, so they are not queued.
- in_handler:
  - mret_commit clears it.
  - A redirect in the same cycle as mret_commit sets it (set wins).
  - Exceptions are still taken while in_handler = 1; interrupts are not.
- trap_cause and trap_pc hold their value until the next IDLE capture.
- Back-to-back traps: minimum spacing from one take_trap_raw to the next is 2 cycles (ISSUE -> IDLE -> ISSUE).
- Reset asserted mid-trap: immediate return to IDLE with all outputs 0; no cu_intr_ack is emitted.

Test Plan:
- ex_exc_v=1, ex_exc_cause=2, ex_pc=0x100 at cycle 5; take_trap=1 in ISSUE -> take_trap_raw/trap_set high in cycle 6 only; trap_cause=2, trap_pc=0x100; flush_pipe high in cycle 6; in_handler=1 from cycle 7; cu_intr_ack stays 0.
- mem_exc_v (cause 5, pc 0x200), ex_exc_v (cause 2) and id_exc_v (cause 3) all asserted in the same cycle -> trap_cause=5, trap_pc=0x200; exactly one take_trap_raw pulse.
- intr_async rises at cycle 10 with mstatus_mie=mie_meie=1 and intr_pc=0x340 -> intr_synced at cycle 12; take_trap_raw at cycle 13 with cause 0x8000_000B and pc 0x340; take_trap delayed to cycle 14 -> WAIT_REDIR is occupied, flush_pipe high for cycles 13-14, cu_intr_ack pulses at cycle 15.
- Interrupt held high after an interrupt trap -> no second trap while in_handler=1; mret_commit drops in_handler, and the next trap is requested one cycle after the clear.
- take_trap never returned -> redir_err=1 two cycles after take_trap_raw and remains 1; FSM back in IDLE.
- rstn pulled low during ISSUE -> all outputs 0 asynchronously; after release, no take_trap_raw without a new request.
